// File: rtl/ula_muldiv.sv
// Iterative multiply/divide unit with HI/LO result registers.
// One bit per clock: shift-add multiply, restoring shift-subtract divide, sign fix-up on exit.
module ula_muldiv #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       OP,
    input  logic [WIDTH-1:0] In1,
    input  logic [WIDTH-1:0] In2,
    input  logic [WIDTH-1:0] hilo_wdata,
    input  logic             hi_we,
    input  logic             lo_we,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t             state;
    logic               div_r;
    logic               neg_q;
    logic               neg_r;
    logic               zero_div;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   pl;
    logic [WIDTH-1:0]   mcand;

    logic               signed_op;
    logic               neg_a;
    logic               neg_b;
    logic [WIDTH-1:0]   mag_in1;
    logic [WIDTH-1:0]   mag_in2;
    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     shifted;
    logic               fits;
    logic [WIDTH-1:0]   acc_n;
    logic [WIDTH-1:0]   pl_n;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_c;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;

    assign busy = (state != IDLE);

    // Operand magnitudes; the most-negative value maps to 2^(WIDTH-1), which still fits unsigned.
    always_comb begin
        signed_op = ~OP[0];
        neg_a     = signed_op & In2[WIDTH-1];
        neg_b     = signed_op & In1[WIDTH-1];
        mag_in1   = neg_b ? -In1 : In1;
        mag_in2   = neg_a ? -In2 : In2;
    end

    always_comb begin
        add_sum = {1'b0, acc} + {1'b0, mcand};
        shifted = {acc, pl[WIDTH-1]};
        fits    = (shifted >= {1'b0, mcand});
        acc_n   = acc;
        pl_n    = pl;
        if (div_r) begin
            acc_n = fits ? (shifted[WIDTH-1:0] - mcand) : shifted[WIDTH-1:0];
            pl_n  = {pl[WIDTH-2:0], fits};
        end else if (pl[0]) begin
            acc_n = add_sum[WIDTH:1];
            pl_n  = {add_sum[0], pl[WIDTH-1:1]};
        end else begin
            acc_n = {1'b0, acc[WIDTH-1:1]};
            pl_n  = {acc[0], pl[WIDTH-1:1]};
        end
    end

    always_comb begin
        prod   = {acc, pl};
        prod_c = neg_q ? -prod : prod;
        quo    = neg_q ? -pl : pl;
        rem    = neg_r ? -acc : acc;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            div_r       <= 1'b0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            zero_div    <= 1'b0;
            cnt         <= '0;
            acc         <= '0;
            pl          <= '0;
            mcand       <= '0;
            done        <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (hi_we) hi <= hilo_wdata;
                    if (lo_we) lo <= hilo_wdata;
                    if (start) begin
                        div_r <= OP[1];
                        neg_q <= neg_a ^ neg_b;
                        neg_r <= neg_a;
                        acc   <= '0;
                        cnt   <= CNT_W'(WIDTH);
                        if (OP[1]) begin
                            mcand <= mag_in1;
                            if (In1 == '0) begin
                                // Raw dividend parked in pl so FINISH can return it in hi.
                                pl       <= In2;
                                zero_div <= 1'b1;
                                state    <= FINISH;
                            end else begin
                                pl       <= mag_in2;
                                zero_div <= 1'b0;
                                state    <= RUN;
                            end
                        end else begin
                            mcand    <= mag_in2;
                            pl       <= mag_in1;
                            zero_div <= 1'b0;
                            state    <= RUN;
                        end
                    end
                end
                RUN: begin
                    acc <= acc_n;
                    pl  <= pl_n;
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) state <= FINISH;
                end
                FINISH: begin
                    done  <= 1'b1;
                    state <= IDLE;
                    if (div_r) begin
                        div_by_zero <= zero_div;
                        if (zero_div) begin
                            lo <= '1;
                            hi <= pl;
                        end else begin
                            lo <= quo;
                            hi <= rem;
                        end
                    end else begin
                        {hi, lo} <= prod_c;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ula_muldiv.sv
// Self-checking bench for ula_muldiv: directed corner cases plus random operations
// compared against a plain-arithmetic reference model.
module tb_ula_muldiv;

    localparam int W = 32;

    logic         clock = 1'b0;
    logic         reset;
    logic         start;
    logic [1:0]   OP;
    logic [W-1:0] In1;
    logic [W-1:0] In2;
    logic [W-1:0] hilo_wdata;
    logic         hi_we;
    logic         lo_we;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         div_by_zero;

    int   errors = 0;
    int   checks = 0;
    logic model_dbz = 1'b0;

    ula_muldiv #(.WIDTH(W)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .OP          (OP),
        .In1         (In1),
        .In2         (In2),
        .hilo_wdata  (hilo_wdata),
        .hi_we       (hi_we),
        .lo_we       (lo_we),
        .busy        (busy),
        .done        (done),
        .hi          (hi),
        .lo          (lo),
        .div_by_zero (div_by_zero)
    );

    always #5 clock = ~clock;

    // Reference: In1 is multiplier/divisor, In2 multiplicand/dividend.
    function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                  input logic dbz_in, output logic [31:0] mhi, output logic [31:0] mlo,
                                  output logic dbz_out);
        longint          sa, sb, p, q, r;
        longint unsigned ua, ub, up, uq, ur;
        sa = $signed(a);
        sb = $signed(b);
        ua = a;
        ub = b;
        dbz_out = dbz_in;
        mhi = '0;
        mlo = '0;
        case (op)
            2'd0: begin
                p = sa * sb;
                {mhi, mlo} = p;
            end
            2'd1: begin
                up = ua * ub;
                {mhi, mlo} = up;
            end
            default: begin
                if (a == 32'd0) begin
                    mlo = 32'hFFFF_FFFF;
                    mhi = b;
                    dbz_out = 1'b1;
                end else begin
                    dbz_out = 1'b0;
                    if (op == 2'd2) begin
                        q = sb / sa;
                        r = sb % sa;
                        mlo = q[31:0];
                        mhi = r[31:0];
                    end else begin
                        uq = ub / ua;
                        ur = ub % ua;
                        mlo = uq[31:0];
                        mhi = ur[31:0];
                    end
                end
            end
        endcase
    endfunction

    // Issues one operation; lat = clock edges after the accepting edge until done, -1 on timeout.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, output int lat);
        @(negedge clock);
        OP = op;
        In1 = a;
        In2 = b;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        OP  = 2'($urandom);
        In1 = $urandom;
        In2 = $urandom;
        lat = -1;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clock);
            #1;
            if (done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int lat;
        reset = 1'b1;
        start = 1'b0;
        OP = 2'd0;
        In1 = '0;
        In2 = '0;
        hilo_wdata = '0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b expected 0", done); end
        checks++; if (hi !== 32'd0) begin errors++; $display("FAIL reset_hi got %h expected 0", hi); end
        checks++; if (lo !== 32'd0) begin errors++; $display("FAIL reset_lo got %h expected 0", lo); end
        checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dbz got %b expected 0", div_by_zero); end
        // Start presented together with reset release must be taken on the very next edge.
        @(negedge clock);
        reset = 1'b0;
        OP = 2'd1;
        In1 = 32'd6;
        In2 = 32'd7;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL first_edge_busy got %b expected 1", busy); end
        lat = -1;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clock);
            #1;
            if (done) begin lat = i; break; end
        end
        checks++; if (lat != 33) begin errors++; $display("FAIL first_edge_latency got %0d expected 33", lat); end
        checks++; if (lo !== 32'd42) begin errors++; $display("FAIL first_edge_lo got %h expected 2a", lo); end
    endtask

    task automatic test_directed();
        int lat;
        run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
        checks++; if (lat != 33) begin errors++; $display("FAIL multu_max_latency got %0d expected 33", lat); end
        checks++; if (hi !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_max_hi got %h expected fffffffe", hi); end
        checks++; if (lo !== 32'h0000_0001) begin errors++; $display("FAIL multu_max_lo got %h expected 00000001", lo); end
        @(posedge clock);
        #1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_one_cycle got %b expected 0", done); end

        run_op(2'd0, 32'd3, 32'hFFFF_FFF9, lat);
        checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_neg_hi got %h expected ffffffff", hi); end
        checks++; if (lo !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mult_neg_lo got %h expected ffffffeb", lo); end

        run_op(2'd2, 32'd2, 32'hFFFF_FFF9, lat);
        checks++; if (lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_neg_lo got %h expected fffffffd", lo); end
        checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_neg_hi got %h expected ffffffff", hi); end

        // Zero divisor: accepting edge goes straight to FINISH, done on the following edge.
        run_op(2'd3, 32'd0, 32'd100, lat);
        checks++; if (lat != 1) begin errors++; $display("FAIL divzero_latency got %0d expected 1", lat); end
        checks++; if (lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divzero_lo got %h expected ffffffff", lo); end
        checks++; if (hi !== 32'd100) begin errors++; $display("FAIL divzero_hi got %h expected 64", hi); end
        checks++; if (div_by_zero !== 1'b1) begin errors++; $display("FAIL divzero_flag got %b expected 1", div_by_zero); end

        run_op(2'd3, 32'd7, 32'd100, lat);
        checks++; if (lo !== 32'd14) begin errors++; $display("FAIL divu_lo got %h expected e", lo); end
        checks++; if (hi !== 32'd2) begin errors++; $display("FAIL divu_hi got %h expected 2", hi); end
        checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL divu_flag_clear got %b expected 0", div_by_zero); end

        run_op(2'd2, 32'hFFFF_FFFF, 32'h8000_0000, lat);
        checks++; if (lo !== 32'h8000_0000) begin errors++; $display("FAIL div_ovf_lo got %h expected 80000000", lo); end
        checks++; if (hi !== 32'd0) begin errors++; $display("FAIL div_ovf_hi got %h expected 0", hi); end
        checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL div_ovf_flag got %b expected 0", div_by_zero); end
        model_dbz = 1'b0;
    endtask

    task automatic test_hilo_write();
        int lat;
        @(negedge clock);
        hi_we = 1'b1;
        hilo_wdata = 32'h1234_5678;
        @(posedge clock);
        #1;
        hi_we = 1'b0;
        checks++; if (hi !== 32'h1234_5678) begin errors++; $display("FAIL mthi got %h expected 12345678", hi); end
        @(negedge clock);
        lo_we = 1'b1;
        hilo_wdata = 32'h9ABC_DEF0;
        @(posedge clock);
        #1;
        lo_we = 1'b0;
        checks++; if (lo !== 32'h9ABC_DEF0) begin errors++; $display("FAIL mtlo got %h expected 9abcdef0", lo); end
        checks++; if (hi !== 32'h1234_5678) begin errors++; $display("FAIL mtlo_hi_hold got %h expected 12345678", hi); end

        // Write and start on the same edge: write lands, then the result replaces it.
        @(negedge clock);
        OP = 2'd1;
        In1 = 32'd3;
        In2 = 32'd5;
        start = 1'b1;
        hi_we = 1'b1;
        lo_we = 1'b1;
        hilo_wdata = 32'hDEAD_BEEF;
        @(posedge clock);
        #1;
        start = 1'b0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        checks++; if (hi !== 32'hDEAD_BEEF) begin errors++; $display("FAIL coincide_hi_write got %h expected deadbeef", hi); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL coincide_busy got %b expected 1", busy); end
        lat = -1;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clock);
            #1;
            if (done) begin lat = i; break; end
        end
        checks++; if (lat != 33) begin errors++; $display("FAIL coincide_latency got %0d expected 33", lat); end
        checks++; if (hi !== 32'd0) begin errors++; $display("FAIL coincide_hi got %h expected 0", hi); end
        checks++; if (lo !== 32'd15) begin errors++; $display("FAIL coincide_lo got %h expected f", lo); end
    endtask

    task automatic test_random();
        int         lat, exp_lat;
        logic [1:0] op;
        logic [31:0] a, b, mhi, mlo;
        logic       mdbz;
        for (int n = 0; n < 40; n++) begin
            op = 2'($urandom_range(0, 3));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: a = 32'd0;
                1: a = 32'($urandom_range(1, 20));
                2: b = 32'h8000_0000;
                default: ;
            endcase
            model(op, a, b, model_dbz, mhi, mlo, mdbz);
            model_dbz = mdbz;
            exp_lat = (op[1] && a == 32'd0) ? 1 : 33;
            run_op(op, a, b, lat);
            checks++; if (lat != exp_lat) begin errors++; $display("FAIL rand_latency op=%0d got %0d expected %0d", op, lat, exp_lat); end
            checks++; if (hi !== mhi) begin errors++; $display("FAIL rand_hi op=%0d in1=%h in2=%h got %h expected %h", op, a, b, hi, mhi); end
            checks++; if (lo !== mlo) begin errors++; $display("FAIL rand_lo op=%0d in1=%h in2=%h got %h expected %h", op, a, b, lo, mlo); end
            checks++; if (div_by_zero !== mdbz) begin errors++; $display("FAIL rand_dbz op=%0d got %b expected %b", op, div_by_zero, mdbz); end
        end
    endtask

    task automatic test_ignore_mid_run();
        int          ndone, lat;
        logic [31:0] a, b, mhi, mlo, pre_hi, got_hi, got_lo;
        logic        mdbz;
        a = $urandom;
        b = $urandom;
        model(2'd0, a, b, model_dbz, mhi, mlo, mdbz);
        pre_hi = hi;
        ndone = 0;
        lat = -1;
        got_hi = '0;
        got_lo = '0;
        @(negedge clock);
        OP = 2'd0;
        In1 = a;
        In2 = b;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clock);
            #1;
            if (done) begin
                ndone++;
                if (lat < 0) begin lat = i; got_hi = hi; got_lo = lo; end
            end
            if (i == 6) begin
                checks++; if (hi !== pre_hi) begin errors++; $display("FAIL midrun_hi_we got %h expected %h", hi, pre_hi); end
            end
            // Pulse start/writes once in RUN and once in FINISH.
            if (i == 5 || i == 32) begin
                start = 1'b1;
                OP = 2'd3;
                In1 = 32'd1;
                In2 = $urandom;
                hi_we = 1'b1;
                lo_we = 1'b1;
                hilo_wdata = $urandom;
            end else begin
                start = 1'b0;
                hi_we = 1'b0;
                lo_we = 1'b0;
            end
        end
        checks++; if (ndone != 1) begin errors++; $display("FAIL midrun_done_count got %0d expected 1", ndone); end
        checks++; if (lat != 33) begin errors++; $display("FAIL midrun_latency got %0d expected 33", lat); end
        checks++; if (got_hi !== mhi) begin errors++; $display("FAIL midrun_hi got %h expected %h", got_hi, mhi); end
        checks++; if (got_lo !== mlo) begin errors++; $display("FAIL midrun_lo got %h expected %h", got_lo, mlo); end
        checks++; if (hi !== mhi) begin errors++; $display("FAIL midrun_hi_hold got %h expected %h", hi, mhi); end
    endtask

    task automatic test_reset_mid_run();
        int          ndone, lat;
        logic [31:0] a, b, mhi, mlo;
        logic        mdbz;
        @(negedge clock);
        hi_we = 1'b1;
        lo_we = 1'b1;
        hilo_wdata = 32'hA5A5_A5A5;
        @(posedge clock);
        #1;
        hi_we = 1'b0;
        lo_we = 1'b0;
        @(negedge clock);
        OP = 2'd1;
        In1 = 32'hFFFF_0000;
        In2 = 32'h0001_FFFF;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b expected 0", busy); end
        checks++; if (hi !== 32'd0) begin errors++; $display("FAIL rst_mid_hi got %h expected 0", hi); end
        checks++; if (lo !== 32'd0) begin errors++; $display("FAIL rst_mid_lo got %h expected 0", lo); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_mid_done got %b expected 0", done); end
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        model_dbz = 1'b0;
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock);
            #1;
            if (done) ndone++;
        end
        checks++; if (ndone != 0) begin errors++; $display("FAIL rst_mid_no_done got %0d expected 0", ndone); end
        a = $urandom;
        b = $urandom;
        model(2'd2, a, b, model_dbz, mhi, mlo, mdbz);
        run_op(2'd2, a, b, lat);
        checks++; if (lat != ((a == 32'd0) ? 1 : 33)) begin errors++; $display("FAIL rst_after_latency got %0d", lat); end
        checks++; if (hi !== mhi) begin errors++; $display("FAIL rst_after_hi got %h expected %h", hi, mhi); end
        checks++; if (lo !== mlo) begin errors++; $display("FAIL rst_after_lo got %h expected %h", lo, mlo); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_hilo_write();
        test_random();
        test_ignore_mid_run();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
